alu_seq: RTL

- Parametrised, multi-cycle successor to the 8-bit datapath ALU, sitting between the register file and the accumulator bus.
- Adds a START/BUSY/DONE handshake, an async active-low reset, shift/rotate/compare opcodes and an optional iterative multiplier.
- Flags follow Intel semantics and are updated only on completion.
- Results and flags drive the shared bus through OE-controlled tri-states.

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU with START/BUSY/DONE handshake, Intel-style flags and tri-stated result bus.
// Optional shift-add multiplier is built when ALU_SEQ_MUL_EN is defined; otherwise opcode 1100 is illegal.
module alu_seq #(
   parameter int Width = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             OE,
   input  logic             START,
   input  logic [3:0]       OPCODE,
   input  logic [Width-1:0] A,
   input  logic [Width-1:0] B,
   output logic [Width-1:0] ALU_OUT,
   output logic [Width-1:0] ALU_HI,
   output logic             CF,
   output logic             OF,
   output logic             SF,
   output logic             ZF,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);
   localparam int SW  = $clog2(Width);
   localparam int MSB = Width - 1;

   localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0011, OP_AND = 4'b0100,
                          OP_OR  = 4'b0101, OP_XOR = 4'b0110, OP_NOT = 4'b0111,
                          OP_SHL = 4'b1000, OP_SHR = 4'b1001, OP_ROL = 4'b1010,
                          OP_ROR = 4'b1011, OP_CMP = 4'b1101;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1100;
`endif

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

   state_t           state_q;
   logic [3:0]       op_q;
   logic [Width-1:0] a_q, b_q, res_q, hi_q;
   logic             cf_q, of_q, sf_q, zf_q, done_q, err_q;

   logic [SW-1:0]    sh, nsh;
   logic [Width:0]   wide;
   logic [Width-1:0] e_res;
   logic             e_cf, e_of, e_legal, e_wr;

   assign sh  = b_q[SW-1:0];
   assign nsh = '0 - sh;   // complementary shift that closes the rotate loop

   always_comb begin
      wide    = '0;
      e_res   = res_q;
      e_cf    = 1'b0;
      e_of    = 1'b0;
      e_legal = 1'b1;
      e_wr    = 1'b1;
      case (op_q)
         OP_ADD: begin
            wide  = {1'b0, a_q} + {1'b0, b_q};
            e_res = wide[Width-1:0];
            e_cf  = wide[Width];
            e_of  = (a_q[MSB] == b_q[MSB]) && (e_res[MSB] != a_q[MSB]);
         end
         OP_SUB, OP_CMP: begin
            wide  = {1'b0, a_q} - {1'b0, b_q};
            e_res = wide[Width-1:0];
            e_cf  = wide[Width];
            e_of  = (a_q[MSB] != b_q[MSB]) && (e_res[MSB] != a_q[MSB]);
            e_wr  = (op_q != OP_CMP);
         end
         OP_AND: e_res = a_q & b_q;
         OP_OR:  e_res = a_q | b_q;
         OP_XOR: e_res = a_q ^ b_q;
         OP_NOT: e_res = ~a_q;
         // The extra bit catches the last bit shifted out; amount 0 leaves it clear.
         OP_SHL: begin
            wide  = {1'b0, a_q} << sh;
            e_res = wide[Width-1:0];
            e_cf  = wide[Width];
         end
         OP_SHR: begin
            wide  = {a_q, 1'b0} >> sh;
            e_res = wide[Width:1];
            e_cf  = wide[0];
         end
         OP_ROL: begin
            e_res = (a_q << sh) | (a_q >> nsh);
            e_cf  = (sh != '0) && e_res[0];
         end
         OP_ROR: begin
            e_res = (a_q >> sh) | (a_q << nsh);
            e_cf  = (sh != '0) && e_res[MSB];
         end
         default: e_legal = 1'b0;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   logic [SW-1:0]      cnt_q;
   logic [2*Width-1:0] acc_q, mul_nxt;

   assign mul_nxt = acc_q + (b_q[cnt_q] ? ({{Width{1'b0}}, a_q} << cnt_q) : '0);
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         hi_q    <= '0;
         cf_q    <= 1'b0;
         of_q    <= 1'b0;
         sf_q    <= 1'b0;
         zf_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         cnt_q   <= '0;
         acc_q   <= '0;
`endif
      end else if (EN) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: if (START) begin
               a_q  <= A;
               b_q  <= B;
               op_q <= OPCODE;
`ifdef ALU_SEQ_MUL_EN
               if (OPCODE == OP_MUL) begin
                  state_q <= S_MUL;
                  cnt_q   <= '0;
                  acc_q   <= '0;
               end else
`endif
                  state_q <= S_EXEC;
            end
            S_EXEC: begin
               done_q  <= 1'b1;
               err_q   <= !e_legal;
               state_q <= S_IDLE;
               if (e_legal) begin
                  if (e_wr) res_q <= e_res;
                  hi_q <= '0;
                  cf_q <= e_cf;
                  of_q <= e_of;
                  sf_q <= e_res[MSB];
                  zf_q <= (e_res == '0);
               end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
               if (cnt_q == SW'(Width - 1)) begin
                  res_q   <= mul_nxt[Width-1:0];
                  hi_q    <= mul_nxt[2*Width-1:Width];
                  cf_q    <= |mul_nxt[2*Width-1:Width];
                  of_q    <= |mul_nxt[2*Width-1:Width];
                  sf_q    <= mul_nxt[2*Width-1];
                  zf_q    <= (mul_nxt == '0);
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= mul_nxt;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ALU_OUT = OE ? res_q : 'z;
   assign ALU_HI  = OE ? hi_q  : 'z;
   assign CF      = OE ? cf_q  : 1'bz;
   assign OF      = OE ? of_q  : 1'bz;
   assign SF      = OE ? sf_q  : 1'bz;
   assign ZF      = OE ? zf_q  : 1'bz;
   assign BUSY    = (state_q != S_IDLE);
   assign DONE    = done_q;
   assign ERR     = err_q;
endmodule
